// File: rtl/connect4_pkg.sv
// Shared definitions for the 4x4 connect board: geometry, status codes
// reported by the winner detector, controller states and cell indexing.
package connect4_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  localparam logic [1:0] STILL_PLAYING = 2'b00;
  localparam logic [1:0] P1_WINS       = 2'b01;
  localparam logic [1:0] P2_WINS       = 2'b10;
  localparam logic [1:0] TIE           = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SETTLE = 2'd2,
    OVER   = 2'd3
  } ctrl_state_t;

  // Bit position of (row, col) in the board vectors: 4*row + col.
  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/drop_controller.sv
// Board writer: accepts a column drop, scans upward one row per cycle for
// the first empty cell, writes it for the player to move, then waits two
// cycles for the winner detector before taking the next move or freezing.
module drop_controller
  import connect4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [1:0]  move_col,
  output logic        move_ready,
  input  logic [1:0]  game_status,
  output logic [15:0] game_board,
  output logic [15:0] player_cells,
  output logic        current_player,
  output logic        move_done,
  output logic        move_error,
  output logic        game_over
);

  ctrl_state_t state;
  logic [1:0]  col;
  logic [1:0]  row;
  logic        settle_cnt;
  logic [3:0]  idx;

  assign idx        = cell_idx(row, col);
  assign move_ready = (state == IDLE);
  assign game_over  = (state == OVER);

  // Control FSM and board datapath; pulses default low every cycle.
  always_ff @(posedge clk) begin
    move_done  <= 1'b0;
    move_error <= 1'b0;
    if (reset || new_game) begin
      state          <= IDLE;
      game_board     <= '0;
      player_cells   <= '0;
      current_player <= 1'b0;
      col            <= '0;
      row            <= '0;
      settle_cnt     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (move_valid) begin
            col   <= move_col;
            row   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!game_board[idx]) begin
            // Landing cell found: exactly one write per accepted move.
            game_board[idx]   <= 1'b1;
            player_cells[idx] <= current_player;
            current_player    <= ~current_player;
            settle_cnt        <= 1'b0;
            move_done         <= 1'b1;
            state             <= SETTLE;
          end else if (row == 2'(ROWS - 1)) begin
            // Column full: discard without touching board or turn.
            move_error <= 1'b1;
            state      <= IDLE;
          end else begin
            row <= row + 2'd1;
          end
        end
        SETTLE: begin
          // The detector is one register behind the board, so its status
          // is only trusted on the second settle cycle.
          if (!settle_cnt) begin
            settle_cnt <= 1'b1;
          end else begin
            state <= (game_status == STILL_PLAYING) ? IDLE : OVER;
          end
        end
        OVER: state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
